// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers,
// with frame sequencing, inter-frame gap and deferred baud select. Optional: TX_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [1:0]                   cfg_sel,
  input  logic                         cfg_sel_we,
  output logic [1:0]                   uart_sel,
  output logic                         uart_tx_start,
  output logic [DATA_W-1:0]            uart_tx_data,
  input  logic                         uart_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         arb_busy,
  output logic                         timeout_err
);

  localparam int IdW    = $clog2(NUM_REQ);
  localparam int CntMax = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CntW   = (CntMax < 1) ? 1 : $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t              state_q, state_d;
  logic [IdW-1:0]      grant_q, grant_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          pendSel_q, pendSel_d;
  logic                pendVld_q, pendVld_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                found;
  logic [IdW-1:0]      winner;
  logic [DATA_W-1:0]   winData;

  // Search starts one past the last grant so every waiting requester gets a turn.
  always_comb begin
    found   = 1'b0;
    winner  = grant_q;
    winData = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[(int'(grant_q) + k) % NUM_REQ]) begin
        found   = 1'b1;
        winner  = IdW'((int'(grant_q) + k) % NUM_REQ);
        winData = req_data[((int'(grant_q) + k) % NUM_REQ) * DATA_W +: DATA_W];
      end
    end
  end

`ifdef TX_TIMEOUT_EN
  logic toErr_q, toErr_d;
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    data_d        = data_q;
    sel_d         = sel_q;
    pendSel_d     = pendSel_q;
    pendVld_d     = pendVld_q;
    cnt_d         = '0;
    req_ready     = '0;
    uart_tx_start = 1'b0;
`ifdef TX_TIMEOUT_EN
    toErr_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A same-cycle cfg write also holds off the grant so the new baud lands first.
        if (pendVld_q) begin
          sel_d     = pendSel_q;
          pendVld_d = 1'b0;
        end else if (!cfg_sel_we && found) begin
          grant_d = winner;
          data_d  = winData;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        req_ready[grant_q] = 1'b1;
        uart_tx_start      = 1'b1;
        state_d            = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        uart_tx_start = 1'b1;
        if (uart_tx_busy) begin
          state_d = WAIT_DONE;
`ifdef TX_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          toErr_d = 1'b1;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (cfg_sel_we) begin
      pendSel_d = cfg_sel;
      pendVld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      data_q    <= '0;
      sel_q     <= '0;
      pendSel_q <= '0;
      pendVld_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      pendSel_q <= pendSel_d;
      pendVld_q <= pendVld_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      toErr_q <= 1'b0;
    end else begin
      toErr_q <= toErr_d;
    end
  end

  assign timeout_err = toErr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign uart_sel     = sel_q;
  assign uart_tx_data = data_q;
  assign grant_id     = grant_q;
  assign arb_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (default parameters); bench also
// covers the TX_TIMEOUT_EN build when that macro is defined.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [1:0]  cfg_sel;
  logic        cfg_sel_we;
  logic [1:0]  uart_sel;
  logic        uart_tx_start;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_busy;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cfg_sel(cfg_sel), .cfg_sel_we(cfg_sel_we), .uart_sel(uart_sel),
    .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data),
    .uart_tx_busy(uart_tx_busy), .grant_id(grant_id),
    .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d);
    req_valid = v;
    req_data  = d;
  endtask

  // From WAIT_BUSY: UART raises busy, holds it, then drops; ends in IDLE.
  task automatic serveFrame();
    uart_tx_busy = 1'b1;
    tick();
    tick();
    uart_tx_busy = 1'b0;
    tick();
    tick();
    tick();
  endtask

  logic [1:0]  rrIds  [4];
  logic [7:0]  rrBytes[4];
  logic        allHigh;
  logic        errSeen;

  initial begin
    rrIds   = '{2'd1, 2'd3, 2'd0, 2'd1};
    rrBytes = '{8'hA1, 8'hA3, 8'hA0, 8'hA1};
    rstn = 1'b1; cfg_sel = 2'd0; cfg_sel_we = 1'b0; uart_tx_busy = 1'b0;
    applyStimulus(4'b0000, 32'h0);
    #2 rstn = 1'b0;
    tick();
    tick();
    checkOutput("rst_start", uart_tx_start, 0);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_sel", uart_sel, 0);
    checkOutput("rst_grant", grant_id, 0);
    checkOutput("rst_busy", arb_busy, 0);
    checkOutput("rst_data", uart_tx_data, 0);
    checkOutput("rst_toerr", timeout_err, 0);
    rstn = 1'b1;
    tick();

    $display("[TB] single request");
    applyStimulus(4'b0100, 32'h0021_0000);
    tick();
    checkOutput("t1_ready", req_ready, 4'b0100);
    checkOutput("t1_start", uart_tx_start, 1);
    checkOutput("t1_data", uart_tx_data, 8'h21);
    checkOutput("t1_grant", grant_id, 2);
    checkOutput("t1_sel", uart_sel, 0);
    applyStimulus(4'b0000, 32'h0);
    tick();
    checkOutput("t1_wb_ready", req_ready, 0);
    checkOutput("t1_wb_start", uart_tx_start, 1);
    tick();
    checkOutput("t1_wb_start2", uart_tx_start, 1);
    uart_tx_busy = 1'b1;
    tick();
    checkOutput("t1_wd_start", uart_tx_start, 0);
    tick();
    checkOutput("t1_wd_data", uart_tx_data, 8'h21);
    uart_tx_busy = 1'b0;
    tick();
    checkOutput("t1_gap0_busy", arb_busy, 1);
    tick();
    checkOutput("t1_gap1_busy", arb_busy, 1);
    tick();
    checkOutput("t1_idle_busy", arb_busy, 0);

    $display("[TB] round robin");
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    applyStimulus(4'b1011, 32'hA3_00_A1_A0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("rr%0d_grant", i), grant_id, rrIds[i]);
      checkOutput($sformatf("rr%0d_data", i), uart_tx_data, rrBytes[i]);
      checkOutput($sformatf("rr%0d_ready", i), req_ready, 4'b0001 << rrIds[i]);
      tick();
      serveFrame();
      checkOutput($sformatf("rr%0d_idle", i), arb_busy, 0);
    end
    applyStimulus(4'b0000, 32'h0);

    $display("[TB] deferred baud change");
    applyStimulus(4'b0001, 32'h0000_00B0);
    tick();
    checkOutput("db_grant", grant_id, 0);
    applyStimulus(4'b0000, 32'h0);
    tick();
    uart_tx_busy = 1'b1;
    tick();
    cfg_sel = 2'd3; cfg_sel_we = 1'b1;
    tick();
    cfg_sel_we = 1'b0;
    checkOutput("db_sel_wd", uart_sel, 0);
    applyStimulus(4'b1000, 32'hC3_00_00_00);
    uart_tx_busy = 1'b0;
    tick();
    checkOutput("db_sel_gap", uart_sel, 0);
    tick();
    tick();
    checkOutput("db_sel_idle", uart_sel, 0);
    checkOutput("db_idle_busy", arb_busy, 0);
    tick();
    checkOutput("db_sel_applied", uart_sel, 3);
    checkOutput("db_no_grant", req_ready, 0);
    tick();
    checkOutput("db_late_ready", req_ready, 4'b1000);
    checkOutput("db_late_grant", grant_id, 3);
    applyStimulus(4'b0000, 32'h0);
    tick();
    serveFrame();

    $display("[TB] simultaneous cfg write and request");
    cfg_sel = 2'd1; cfg_sel_we = 1'b1;
    applyStimulus(4'b0001, 32'h0000_005A);
    tick();
    cfg_sel_we = 1'b0;
    checkOutput("sim_ready0", req_ready, 0);
    checkOutput("sim_sel0", uart_sel, 3);
    tick();
    checkOutput("sim_sel1", uart_sel, 1);
    checkOutput("sim_ready1", req_ready, 0);
    tick();
    checkOutput("sim_ready2", req_ready, 4'b0001);
    checkOutput("sim_data2", uart_tx_data, 8'h5A);
    applyStimulus(4'b0000, 32'h0);
    tick();
    uart_tx_busy = 1'b1;
    tick();

    $display("[TB] reset mid-frame");
    checkOutput("mr_pre_busy", arb_busy, 1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("mr_start", uart_tx_start, 0);
    checkOutput("mr_ready", req_ready, 0);
    checkOutput("mr_sel", uart_sel, 0);
    checkOutput("mr_grant", grant_id, 0);
    checkOutput("mr_busy", arb_busy, 0);
    uart_tx_busy = 1'b0;
    tick();
    rstn = 1'b1;
    applyStimulus(4'b0011, 32'h0000_6655);
    tick();
    checkOutput("mr_new_grant", grant_id, 1);
    checkOutput("mr_new_ready", req_ready, 4'b0010);
    checkOutput("mr_new_data", uart_tx_data, 8'h66);
    applyStimulus(4'b0000, 32'h0);
    tick();
    serveFrame();

    $display("[TB] busy never rises");
    applyStimulus(4'b1000, 32'hC3_00_00_00);
    tick();
    checkOutput("to_grant", grant_id, 3);
    applyStimulus(4'b0000, 32'h0);
    tick();
    allHigh = 1'b1;
    errSeen = 1'b0;
`ifdef TX_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      tick();
      allHigh &= uart_tx_start;
      errSeen |= timeout_err;
    end
    checkOutput("to_start_held", allHigh, 1);
    checkOutput("to_no_early_err", errSeen, 0);
    tick();
    checkOutput("to_err_pulse", timeout_err, 1);
    checkOutput("to_start_drop", uart_tx_start, 0);
    checkOutput("to_gap_busy", arb_busy, 1);
    tick();
    checkOutput("to_err_clear", timeout_err, 0);
    tick();
    checkOutput("to_idle", arb_busy, 0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      allHigh &= uart_tx_start;
      errSeen |= timeout_err;
    end
    checkOutput("nto_start_held", allHigh, 1);
    checkOutput("nto_no_err", errSeen, 0);
    serveFrame();
    checkOutput("nto_idle", arb_busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
